// File: rtl/mips_multi_control_fsm_pkg.sv
// -----------------------------------------------------------------------------
// CU_my_pkg
// Shared definitions for the multicycle MIPS main control unit:
//   - field widths (opcode, funct, ALUControl, state)
//   - state encoding (values are fixed and visible on State_o)
//   - opcode / funct constants
//   - ALUOp and ALUControl codes
//   - helper that tells whether an opcode is handled by the FSM
// -----------------------------------------------------------------------------
package CU_my_pkg;

    localparam int OP_W     = 6;
    localparam int FUNCT_W  = 6;
    localparam int ALUCTL_W = 3;
    localparam int ST_W     = 4;

    // Encodings 12..15 are unused; the FSM falls back to FETCH from them.
    typedef enum logic [ST_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'h20;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'h22;
    localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'h24;
    localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'h25;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'h2A;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [ALUCTL_W-1:0] ALUCTL_AND = 3'b000;
    localparam logic [ALUCTL_W-1:0] ALUCTL_OR  = 3'b001;
    localparam logic [ALUCTL_W-1:0] ALUCTL_ADD = 3'b010;
    localparam logic [ALUCTL_W-1:0] ALUCTL_SUB = 3'b110;
    localparam logic [ALUCTL_W-1:0] ALUCTL_SLT = 3'b111;

    // True for every opcode that has its own path through the FSM.
    function automatic logic is_supported_op(input logic [OP_W-1:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: ok = 1'b1;
            default:                                       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mips_multi_control_fsm_alu_decoder.sv
// -----------------------------------------------------------------------------
// cu_alu_decoder
// Combinational ALU decoder: turns the FSM's ALUOp plus the instruction funct
// field into the 3-bit ALUControl code.
//   alu_op_i      : 00 add, 01 sub, 10 decode funct
//   funct_i       : instr[5:0]
//   alu_control_o : 010 add, 110 sub, 000 and, 001 or, 111 slt
// -----------------------------------------------------------------------------
module cu_alu_decoder
    import CU_my_pkg::*;
(
    input  logic [1:0]          alu_op_i,
    input  logic [FUNCT_W-1:0]  funct_i,
    output logic [ALUCTL_W-1:0] alu_control_o
);

    // ALUOp / funct to ALUControl; unknown funct and ALUOp=11 fall back to add.
    always_comb begin
        alu_control_o = ALUCTL_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALUCTL_ADD;
            ALUOP_SUB: alu_control_o = ALUCTL_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FUNCT_ADD: alu_control_o = ALUCTL_ADD;
                    FUNCT_SUB: alu_control_o = ALUCTL_SUB;
                    FUNCT_AND: alu_control_o = ALUCTL_AND;
                    FUNCT_OR:  alu_control_o = ALUCTL_OR;
                    FUNCT_SLT: alu_control_o = ALUCTL_SLT;
                    default:   alu_control_o = ALUCTL_ADD;
                endcase
            end
            default: alu_control_o = ALUCTL_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multi_control_fsm.sv
// -----------------------------------------------------------------------------
// mips_multi_control_fsm
// Main control unit of a multicycle MIPS datapath. Moore FSM sequenced by the
// opcode held in the instruction register, plus the ALU decoder.
//   clk, reset     : rising-edge clock, synchronous active-high reset (-> FETCH)
//   Opcode_i       : instr[31:26]       Funct_i : instr[5:0]
//   Zero_i         : ALU zero flag, only used to qualify branches
//   PC_En_o        : PCWrite | (Branch & Zero_i), combinational on Zero_i
//   IorD_o, Mem_Write_o, IR_Write_o, Reg_Write_o, RegDst_o, MemtoReg_o,
//   ALUSrcA_o, ALUSrcB_o, PCSrc_o : datapath controls, functions of state only
//   ALUControl_o   : from cu_alu_decoder
//   Illegal_Op_o   : single-cycle pulse in DECODE for an unsupported opcode
//   State_o        : current state encoding (debug)
// -----------------------------------------------------------------------------
module mips_multi_control_fsm
    import CU_my_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [OP_W-1:0]     Opcode_i,
    input  logic [FUNCT_W-1:0]  Funct_i,
    input  logic                Zero_i,
    output logic                PC_En_o,
    output logic                IorD_o,
    output logic                Mem_Write_o,
    output logic                IR_Write_o,
    output logic                Reg_Write_o,
    output logic                RegDst_o,
    output logic                MemtoReg_o,
    output logic                ALUSrcA_o,
    output logic [1:0]          ALUSrcB_o,
    output logic [1:0]          PCSrc_o,
    output logic [ALUCTL_W-1:0] ALUControl_o,
    output logic                Illegal_Op_o,
    output logic [ST_W-1:0]     State_o
);

    state_t     state_q;
    state_t     state_d;

    logic       pc_write_s;
    logic       branch_s;
    logic [1:0] alu_op_s;

    // State register; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; opcode is only looked at in DECODE and MEMADR.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (Opcode_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (Opcode_i == OP_LW) begin
                    state_d = S_MEMREAD;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_ADDIEXEC: state_d = S_ADDIWB;
            S_ADDIWB:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Moore output decode; everything not named in a state stays 0.
    always_comb begin
        pc_write_s   = 1'b0;
        branch_s     = 1'b0;
        alu_op_s     = ALUOP_ADD;
        IorD_o       = 1'b0;
        Mem_Write_o  = 1'b0;
        IR_Write_o   = 1'b0;
        Reg_Write_o  = 1'b0;
        RegDst_o     = 1'b0;
        MemtoReg_o   = 1'b0;
        ALUSrcA_o    = 1'b0;
        ALUSrcB_o    = 2'b00;
        PCSrc_o      = 2'b00;
        Illegal_Op_o = 1'b0;
        case (state_q)
            S_FETCH: begin
                IR_Write_o = 1'b1;
                ALUSrcB_o  = 2'b01;
                pc_write_s = 1'b1;
            end
            S_DECODE: begin
                ALUSrcB_o    = 2'b11;
                // Only output that looks at the opcode: flags the bad fetch.
                Illegal_Op_o = ~is_supported_op(Opcode_i);
            end
            S_MEMADR: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
            end
            S_MEMREAD: begin
                IorD_o = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg_o  = 1'b1;
                Reg_Write_o = 1'b1;
            end
            S_MEMWRITE: begin
                IorD_o      = 1'b1;
                Mem_Write_o = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA_o = 1'b1;
                alu_op_s  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegDst_o    = 1'b1;
                Reg_Write_o = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA_o = 1'b1;
                alu_op_s  = ALUOP_SUB;
                PCSrc_o   = 2'b01;
                branch_s  = 1'b1;
            end
            S_ADDIEXEC: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
            end
            S_ADDIWB: begin
                Reg_Write_o = 1'b1;
            end
            S_JUMP: begin
                PCSrc_o    = 2'b10;
                pc_write_s = 1'b1;
            end
            default: begin
                pc_write_s = 1'b0;
            end
        endcase
    end

    // Branch qualification is deliberately combinational on Zero_i so the PC
    // load follows the ALU compare result within the BRANCH cycle.
    assign PC_En_o = pc_write_s | (branch_s & Zero_i);
    assign State_o = state_q;

    cu_alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op_s),
        .funct_i       (Funct_i),
        .alu_control_o (ALUControl_o)
    );

endmodule

// File: tb/tb_mips_multi_control_fsm.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for mips_multi_control_fsm. The driver issues whole
// instructions (directed ones first, then random), and for every half-cycle
// pushes the expected output vector derived from the instruction's state path
// and the per-state control table. Zero_i is re-randomised mid-cycle so the
// combinational PC_En_o path is exercised. A monitor samples twice per cycle
// and compares against the queue.
// -----------------------------------------------------------------------------
module tb_mips_multi_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Opcode_i;
    logic [5:0] Funct_i;
    logic       Zero_i;
    logic       PC_En_o, IorD_o, Mem_Write_o, IR_Write_o, Reg_Write_o;
    logic       RegDst_o, MemtoReg_o, ALUSrcA_o, Illegal_Op_o;
    logic [1:0] ALUSrcB_o, PCSrc_o;
    logic [2:0] ALUControl_o;
    logic [3:0] State_o;

    typedef struct packed {
        logic [3:0] st;
        logic       ir_w;
        logic       pc_en;
        logic       iord;
        logic       mem_w;
        logic       reg_w;
        logic       reg_dst;
        logic       m2r;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic [2:0] aluctl;
        logic       illegal;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mips_multi_control_fsm dut (
        .clk          (clk),
        .reset        (reset),
        .Opcode_i     (Opcode_i),
        .Funct_i      (Funct_i),
        .Zero_i       (Zero_i),
        .PC_En_o      (PC_En_o),
        .IorD_o       (IorD_o),
        .Mem_Write_o  (Mem_Write_o),
        .IR_Write_o   (IR_Write_o),
        .Reg_Write_o  (Reg_Write_o),
        .RegDst_o     (RegDst_o),
        .MemtoReg_o   (MemtoReg_o),
        .ALUSrcA_o    (ALUSrcA_o),
        .ALUSrcB_o    (ALUSrcB_o),
        .PCSrc_o      (PCSrc_o),
        .ALUControl_o (ALUControl_o),
        .Illegal_Op_o (Illegal_Op_o),
        .State_o      (State_o)
    );

    function automatic logic supported(input logic [5:0] op);
        return (op == 6'h00) || (op == 6'h02) || (op == 6'h04) ||
               (op == 6'h08) || (op == 6'h23) || (op == 6'h2B);
    endfunction

    // Instruction latency in cycles.
    function automatic int path_len(input logic [5:0] op);
        case (op)
            6'h23:               return 5;
            6'h2B, 6'h00, 6'h08: return 4;
            6'h04, 6'h02:        return 3;
            default:             return 2;
        endcase
    endfunction

    // State number visited in cycle k of an instruction.
    function automatic int path_state(input logic [5:0] op, input int k);
        if (k == 0) return 0;
        if (k == 1) return 1;
        case (op)
            6'h23:   return (k == 2) ? 2 : ((k == 3) ? 3 : 4);
            6'h2B:   return (k == 2) ? 2 : 5;
            6'h00:   return (k == 2) ? 6 : 7;
            6'h08:   return (k == 2) ? 9 : 10;
            6'h04:   return 8;
            6'h02:   return 11;
            default: return 0;
        endcase
    endfunction

    function automatic logic [2:0] funct_ctl(input logic [5:0] fn);
        case (fn)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2A:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    // Control table: outputs seen in a given state with given inputs.
    function automatic exp_t model(input int st, input logic [5:0] op,
                                   input logic [5:0] fn, input logic z);
        exp_t e;
        e        = '0;
        e.st     = 4'(st);
        e.aluctl = 3'b010;
        case (st)
            0: begin e.ir_w = 1'b1; e.srcb = 2'b01; e.pc_en = 1'b1; end
            1: begin e.srcb = 2'b11; e.illegal = ~supported(op); end
            2: begin e.srca = 1'b1; e.srcb = 2'b10; end
            3: e.iord = 1'b1;
            4: begin e.m2r = 1'b1; e.reg_w = 1'b1; end
            5: begin e.iord = 1'b1; e.mem_w = 1'b1; end
            6: begin e.srca = 1'b1; e.aluctl = funct_ctl(fn); end
            7: begin e.reg_dst = 1'b1; e.reg_w = 1'b1; end
            8: begin e.srca = 1'b1; e.aluctl = 3'b110; e.pcsrc = 2'b01; e.pc_en = z; end
            9: begin e.srca = 1'b1; e.srcb = 2'b10; end
            10: e.reg_w = 1'b1;
            11: begin e.pcsrc = 2'b10; e.pc_en = 1'b1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    // One cycle of stimulus: inputs at posedge+1, Zero_i changed at negedge+1.
    task automatic drive_cycle(input int st, input logic [5:0] op,
                               input logic [5:0] fn, input logic rst);
        logic za;
        logic zb;
        za       = 1'($urandom_range(0, 1));
        zb       = 1'($urandom_range(0, 1));
        Opcode_i = op;
        Funct_i  = fn;
        Zero_i   = za;
        reset    = rst;
        exp_q.push_back(model(st, op, fn, za));
        exp_q.push_back(model(st, op, fn, zb));
        @(negedge clk);
        #1 Zero_i = zb;
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction; reset_at >= 0 asserts reset in that cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int reset_at);
        int n;
        n = path_len(op);
        for (int k = 0; k < n; k++) begin
            if (k == 0) begin
                // IR is being loaded in FETCH: present unrelated bits.
                drive_cycle(0, 6'($urandom), 6'($urandom), k == reset_at);
            end else begin
                drive_cycle(path_state(op, k), op, fn, k == reset_at);
            end
            if (k == reset_at) begin
                reset = 1'b0;
                break;
            end
        end
    endtask

    task automatic check_now();
        exp_t e;
        exp_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {State_o, IR_Write_o, PC_En_o, IorD_o, Mem_Write_o, Reg_Write_o,
                 RegDst_o, MemtoReg_o, ALUSrcA_o, ALUSrcB_o, PCSrc_o,
                 ALUControl_o, Illegal_Op_o};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL outputs t=%0t state exp=%0d got=%0d vec got=%h exp=%h (st,irw,pcen,iord,memw,regw,regdst,m2r,srca,srcb,pcsrc,aluctl,ill)",
                         $time, e.st, a.st, a, e);
            end
        end
    endtask

    // Monitor: sample once early in the low phase and once just before posedge.
    initial begin
        forever begin
            @(negedge clk);
            check_now();
            #4;
            check_now();
        end
    end

    logic [5:0] rop;
    logic [5:0] rfn;
    int         sel;
    int         wait_cnt;

    initial begin
        reset    = 1'b1;
        Opcode_i = 6'h00;
        Funct_i  = 6'h00;
        Zero_i   = 1'b0;
        @(posedge clk);
        #1;
        // Two edges with reset high; FETCH outputs expected after each.
        drive_cycle(0, 6'h00, 6'h00, 1'b1);
        reset = 1'b0;

        run_instr(6'h23, 6'h00, -1);   // lw
        run_instr(6'h00, 6'h22, -1);   // R-type sub
        for (int i = 0; i < 4; i++) run_instr(6'h04, 6'h00, -1); // beq
        run_instr(6'h2B, 6'h00, -1);   // sw
        run_instr(6'h02, 6'h00, -1);   // j
        run_instr(6'h3F, 6'h00, -1);   // illegal
        run_instr(6'h23, 6'h00, 3);    // lw, reset in MEMREAD
        run_instr(6'h08, 6'h00, -1);   // addi
        run_instr(6'h00, 6'h2A, -1);   // R-type slt

        for (int i = 0; i < 120; i++) begin
            sel = int'($urandom_range(0, 6));
            case (sel)
                0: rop = 6'h23;
                1: rop = 6'h2B;
                2: rop = 6'h00;
                3: rop = 6'h04;
                4: rop = 6'h08;
                5: rop = 6'h02;
                default: begin
                    rop = 6'($urandom);
                    while (supported(rop)) rop = 6'($urandom);
                end
            endcase
            case ($urandom_range(0, 5))
                0: rfn = 6'h20;
                1: rfn = 6'h22;
                2: rfn = 6'h24;
                3: rfn = 6'h25;
                4: rfn = 6'h2A;
                default: rfn = 6'($urandom);
            endcase
            if ($urandom_range(0, 9) == 0) begin
                run_instr(rop, rfn, int'($urandom_range(0, path_len(rop) - 1)));
            end else begin
                run_instr(rop, rfn, -1);
            end
        end

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
